// File: rtl/otter_pkg.sv
// Shared definitions: reservation-station tag type, memory size encodings and
// the store-queue head FSM state type.
// Pure declarations; no logic, no latency, no flow control.
package otter_pkg;

    localparam int TAG_W = 4;

    typedef logic [TAG_W-1:0] RS_tag_type;

    // mem_type[1:0] size encodings
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        RESP  = 2'd2
    } sq_state_e;

    // Halfwords need an even address, words a 4-byte aligned one.
    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        return ((size == SZ_HALF) && addr_lo[0]) ||
               ((size == SZ_WORD) && (addr_lo != 2'b00));
    endfunction

endpackage

// File: rtl/sq_entry.sv
// One store-queue slot: tag, mem_type and three operands with CDB snooping.
// Written in one cycle; an operand becomes valid the edge after its broadcast.
// No backpressure: the owner decides when to write or clear the slot.
module sq_entry #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 4
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             wr_en,
    input  logic             clr,
    input  logic [TAG_W-1:0] issue_tag,
    input  logic [XLEN-1:0]  issue_v1,
    input  logic [XLEN-1:0]  issue_v2,
    input  logic [XLEN-1:0]  issue_v3,
    input  logic             issue_v1_ok,
    input  logic             issue_v2_ok,
    input  logic             issue_v3_ok,
    input  logic [TAG_W-1:0] issue_q1,
    input  logic [TAG_W-1:0] issue_q2,
    input  logic [TAG_W-1:0] issue_q3,
    input  logic [2:0]       issue_mem_type,
    input  logic             cdb_valid,
    input  logic [TAG_W-1:0] cdb_tag,
    input  logic [XLEN-1:0]  cdb_data,
    output logic             vld,
    output logic [TAG_W-1:0] tag,
    output logic [XLEN-1:0]  v1,
    output logic [XLEN-1:0]  v2,
    output logic [XLEN-1:0]  v3,
    output logic [2:0]       ok,
    output logic [2:0]       mem_type
);

    logic [XLEN-1:0]  in_v [3];
    logic [TAG_W-1:0] in_q [3];
    logic [2:0]       in_ok;

    logic             vld_q;
    logic [TAG_W-1:0] tag_q;
    logic [2:0]       mem_type_q;
    logic [XLEN-1:0]  val_q [3];
    logic [TAG_W-1:0] q_q [3];
    logic [2:0]       ok_q;

    assign in_v[0] = issue_v1;
    assign in_v[1] = issue_v2;
    assign in_v[2] = issue_v3;
    assign in_q[0] = issue_q1;
    assign in_q[1] = issue_q2;
    assign in_q[2] = issue_q3;
    assign in_ok   = {issue_v3_ok, issue_v2_ok, issue_v1_ok};

    // Slot write (with same-cycle broadcast capture), clear, or operand snoop.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            vld_q      <= 1'b0;
            tag_q      <= '0;
            mem_type_q <= '0;
            ok_q       <= '0;
            for (int k = 0; k < 3; k++) begin
                val_q[k] <= '0;
                q_q[k]   <= '0;
            end
        end else if (wr_en) begin
            vld_q      <= 1'b1;
            tag_q      <= issue_tag;
            mem_type_q <= issue_mem_type;
            for (int k = 0; k < 3; k++) begin
                q_q[k] <= in_q[k];
                if (in_ok[k]) begin
                    val_q[k] <= in_v[k];
                    ok_q[k]  <= 1'b1;
                end else if (cdb_valid && (cdb_tag == in_q[k])) begin
                    val_q[k] <= cdb_data;
                    ok_q[k]  <= 1'b1;
                end else begin
                    val_q[k] <= in_v[k];
                    ok_q[k]  <= 1'b0;
                end
            end
        end else if (clr) begin
            vld_q <= 1'b0;
        end else if (vld_q) begin
            for (int k = 0; k < 3; k++) begin
                if (!ok_q[k] && cdb_valid && (cdb_tag == q_q[k])) begin
                    val_q[k] <= cdb_data;
                    ok_q[k]  <= 1'b1;
                end
            end
        end
    end

    assign vld      = vld_q;
    assign tag      = tag_q;
    assign v1       = val_q[0];
    assign v2       = val_q[1];
    assign v3       = val_q[2];
    assign ok       = ok_q;
    assign mem_type = mem_type_q;

endmodule

// File: rtl/store_queue.sv
// In-order store queue: circular FIFO of sq_entry slots, head drives memory.
// Head ready -> MEM_WRITE next cycle; MEM_ACK -> done next cycle.
// issue_ready drops when full (no pop bypass); MEM_WRITE holds until MEM_ACK.
module store_queue #(
    parameter int DEPTH = 4,
    parameter int XLEN  = 32,
    parameter int TAG_W = otter_pkg::TAG_W
) (
    input  logic                   CLK,
    input  logic                   RST_N,
    input  logic                   issue_valid,
    output logic                   issue_ready,
    input  logic [TAG_W-1:0]       issue_tag,
    input  logic [XLEN-1:0]        issue_v1,
    input  logic [XLEN-1:0]        issue_v2,
    input  logic [XLEN-1:0]        issue_v3,
    input  logic                   issue_v1_ok,
    input  logic                   issue_v2_ok,
    input  logic                   issue_v3_ok,
    input  logic [TAG_W-1:0]       issue_q1,
    input  logic [TAG_W-1:0]       issue_q2,
    input  logic [TAG_W-1:0]       issue_q3,
    input  logic [2:0]             issue_mem_type,
    input  logic                   cdb_valid,
    input  logic [TAG_W-1:0]       cdb_tag,
    input  logic [XLEN-1:0]        cdb_data,
    output logic [XLEN-1:0]        MEM_ADDR2,
    output logic                   MEM_WRITE,
    output logic [XLEN-1:0]        MEM_WRITE_DATA,
    output logic                   MEM_SIGN,
    output logic [1:0]             MEM_SIZE,
    input  logic                   MEM_ACK,
    output logic                   done,
    output logic [TAG_W-1:0]       done_tag,
    output logic                   done_err,
    input  logic                   flush,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    otter_pkg::sq_state_e state_q;

    logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic [DEPTH-1:0] ent_vld, ent_wr, ent_clr;
    logic [TAG_W-1:0] ent_tag [DEPTH];
    logic [XLEN-1:0]  ent_v1  [DEPTH];
    logic [XLEN-1:0]  ent_v2  [DEPTH];
    logic [XLEN-1:0]  ent_v3  [DEPTH];
    logic [2:0]       ent_ok  [DEPTH];
    logic [2:0]       ent_mt  [DEPTH];

    logic             push, pop;
    logic [XLEN-1:0]  h_addr;
    logic [2:0]       h_mt;
    logic             h_ready, h_misal;

    logic [XLEN-1:0]  mem_addr_q, mem_data_q;
    logic             mem_write_q, mem_sign_q;
    logic [1:0]       mem_size_q;
    logic             done_q, done_err_q;
    logic [TAG_W-1:0] done_tag_q;

    assign issue_ready = (count_q < CNT_W'(DEPTH));
    // A flushed issue is dropped outright.
    assign push        = issue_valid && issue_ready && !flush;
    assign pop         = (state_q == otter_pkg::RESP);

    assign h_addr  = ent_v1[head_q] + ent_v2[head_q];
    assign h_mt    = ent_mt[head_q];
    assign h_ready = ent_vld[head_q] && (&ent_ok[head_q]);
    assign h_misal = otter_pkg::misaligned(h_mt[1:0], h_addr[1:0]);

    for (genvar i = 0; i < DEPTH; i++) begin : g_ent
        // Flush spares only the head while its write is in flight.
        assign ent_wr[i]  = push && (tail_q == PTR_W'(i));
        assign ent_clr[i] = (pop && (head_q == PTR_W'(i))) ||
                            (flush && !((state_q == otter_pkg::WRITE) && (head_q == PTR_W'(i))));

        sq_entry #(.XLEN(XLEN), .TAG_W(TAG_W)) u_ent (
            .CLK            (CLK),
            .RST_N          (RST_N),
            .wr_en          (ent_wr[i]),
            .clr            (ent_clr[i]),
            .issue_tag      (issue_tag),
            .issue_v1       (issue_v1),
            .issue_v2       (issue_v2),
            .issue_v3       (issue_v3),
            .issue_v1_ok    (issue_v1_ok),
            .issue_v2_ok    (issue_v2_ok),
            .issue_v3_ok    (issue_v3_ok),
            .issue_q1       (issue_q1),
            .issue_q2       (issue_q2),
            .issue_q3       (issue_q3),
            .issue_mem_type (issue_mem_type),
            .cdb_valid      (cdb_valid),
            .cdb_tag        (cdb_tag),
            .cdb_data       (cdb_data),
            .vld            (ent_vld[i]),
            .tag            (ent_tag[i]),
            .v1             (ent_v1[i]),
            .v2             (ent_v2[i]),
            .v3             (ent_v3[i]),
            .ok             (ent_ok[i]),
            .mem_type       (ent_mt[i])
        );
    end

    // Next pointers/occupancy; flush keeps an in-flight head as the sole entry.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush) begin
            case (state_q)
                otter_pkg::RESP: begin
                    head_d  = head_q + PTR_W'(1);
                    tail_d  = head_q + PTR_W'(1);
                    count_d = '0;
                end
                otter_pkg::WRITE: begin
                    tail_d  = head_q + PTR_W'(1);
                    count_d = CNT_W'(1);
                end
                default: begin
                    tail_d  = head_q;
                    count_d = '0;
                end
            endcase
        end else begin
            if (push) tail_d = tail_q + PTR_W'(1);
            if (pop)  head_d = head_q + PTR_W'(1);
            if (push && !pop)      count_d = count_q + CNT_W'(1);
            else if (!push && pop) count_d = count_q - CNT_W'(1);
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Head FSM with registered memory and completion outputs.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= otter_pkg::IDLE;
            mem_write_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_data_q  <= '0;
            mem_sign_q  <= 1'b0;
            mem_size_q  <= '0;
            done_q      <= 1'b0;
            done_tag_q  <= '0;
            done_err_q  <= 1'b0;
        end else begin
            done_q     <= 1'b0;
            done_tag_q <= '0;
            done_err_q <= 1'b0;
            case (state_q)
                otter_pkg::IDLE: begin
                    if (h_ready && !flush) begin
                        if (h_misal) begin
                            state_q    <= otter_pkg::RESP;
                            done_q     <= 1'b1;
                            done_tag_q <= ent_tag[head_q];
                            done_err_q <= 1'b1;
                        end else begin
                            state_q     <= otter_pkg::WRITE;
                            mem_write_q <= 1'b1;
                            mem_addr_q  <= h_addr;
                            mem_data_q  <= ent_v3[head_q];
                            mem_sign_q  <= h_mt[2];
                            mem_size_q  <= h_mt[1:0];
                        end
                    end
                end
                otter_pkg::WRITE: begin
                    if (MEM_ACK) begin
                        state_q     <= otter_pkg::RESP;
                        mem_write_q <= 1'b0;
                        mem_addr_q  <= '0;
                        mem_data_q  <= '0;
                        mem_sign_q  <= 1'b0;
                        mem_size_q  <= '0;
                        done_q      <= 1'b1;
                        done_tag_q  <= ent_tag[head_q];
                    end
                end
                otter_pkg::RESP: begin
                    state_q <= otter_pkg::IDLE;
                end
                default: begin
                    state_q <= otter_pkg::IDLE;
                end
            endcase
        end
    end

    assign MEM_WRITE      = mem_write_q;
    assign MEM_ADDR2      = mem_addr_q;
    assign MEM_WRITE_DATA = mem_data_q;
    assign MEM_SIGN       = mem_sign_q;
    assign MEM_SIZE       = mem_size_q;
    assign done           = done_q;
    assign done_tag       = done_tag_q;
    assign done_err       = done_err_q;
    assign count          = count_q;

endmodule

// File: tb/tb_store_queue.sv
// Directed bench for store_queue: issue, CDB capture, full queue, misaligned
// store, flush with in-flight head, reset mid-write, flushed issue.
module tb_store_queue;

    localparam int DEPTH = 4;
    localparam int XLEN  = 32;
    localparam int TAG_W = 4;

    logic             CLK = 1'b0;
    logic             RST_N = 1'b0;
    logic             issue_valid = 1'b0;
    logic             issue_ready;
    logic [TAG_W-1:0] issue_tag = '0;
    logic [XLEN-1:0]  issue_v1 = '0, issue_v2 = '0, issue_v3 = '0;
    logic             issue_v1_ok = 1'b0, issue_v2_ok = 1'b0, issue_v3_ok = 1'b0;
    logic [TAG_W-1:0] issue_q1 = '0, issue_q2 = '0, issue_q3 = '0;
    logic [2:0]       issue_mem_type = '0;
    logic             cdb_valid = 1'b0;
    logic [TAG_W-1:0] cdb_tag = '0;
    logic [XLEN-1:0]  cdb_data = '0;
    logic [XLEN-1:0]  MEM_ADDR2, MEM_WRITE_DATA;
    logic             MEM_WRITE, MEM_SIGN;
    logic [1:0]       MEM_SIZE;
    logic             MEM_ACK = 1'b0;
    logic             done, done_err;
    logic [TAG_W-1:0] done_tag;
    logic             flush = 1'b0;
    logic [$clog2(DEPTH):0] count;

    int errors = 0;
    int checks = 0;

    always #5 CLK = ~CLK;

    store_queue #(.DEPTH(DEPTH), .XLEN(XLEN), .TAG_W(TAG_W)) dut (
        .CLK(CLK), .RST_N(RST_N),
        .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_tag(issue_tag),
        .issue_v1(issue_v1), .issue_v2(issue_v2), .issue_v3(issue_v3),
        .issue_v1_ok(issue_v1_ok), .issue_v2_ok(issue_v2_ok), .issue_v3_ok(issue_v3_ok),
        .issue_q1(issue_q1), .issue_q2(issue_q2), .issue_q3(issue_q3),
        .issue_mem_type(issue_mem_type),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
        .MEM_ADDR2(MEM_ADDR2), .MEM_WRITE(MEM_WRITE), .MEM_WRITE_DATA(MEM_WRITE_DATA),
        .MEM_SIGN(MEM_SIGN), .MEM_SIZE(MEM_SIZE), .MEM_ACK(MEM_ACK),
        .done(done), .done_tag(done_tag), .done_err(done_err),
        .flush(flush), .count(count)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Step to just after the next rising edge.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic issue(input logic [TAG_W-1:0] tag, input logic [XLEN-1:0] v1,
                         input logic [XLEN-1:0] v2, input logic [XLEN-1:0] v3,
                         input logic v3ok, input logic [TAG_W-1:0] q3, input logic [2:0] mt);
        issue_valid    = 1'b1;
        issue_tag      = tag;
        issue_v1       = v1;
        issue_v2       = v2;
        issue_v3       = v3;
        issue_v1_ok    = 1'b1;
        issue_v2_ok    = 1'b1;
        issue_v3_ok    = v3ok;
        issue_q3       = q3;
        issue_mem_type = mt;
        tick();
        issue_valid    = 1'b0;
    endtask

    initial begin
        logic [TAG_W-1:0] got_tags [8];
        int nd;
        int nw;
        logic seen;

        // Reset state
        #3;
        chk("rst_mem_write", MEM_WRITE, 0);
        chk("rst_addr", MEM_ADDR2, 0);
        chk("rst_done", done, 0);
        chk("rst_count", count, 0);
        chk("rst_ready", issue_ready, 1);
        tick();
        RST_N = 1'b1;
        tick();

        // Scenario 1: aligned sw, all operands ready
        issue(4'd1, 32'h100, 32'h4, 32'hDEADBEEF, 1'b1, 4'd0, 3'b010);
        chk("s1_no_write_yet", MEM_WRITE, 0);
        chk("s1_count", count, 1);
        tick();
        chk("s1_write", MEM_WRITE, 1);
        chk("s1_addr", MEM_ADDR2, 32'h104);
        chk("s1_data", MEM_WRITE_DATA, 32'hDEADBEEF);
        chk("s1_size", MEM_SIZE, 2'b10);
        chk("s1_sign", MEM_SIGN, 0);
        tick();
        tick();
        chk("s1_hold_write", MEM_WRITE, 1);
        chk("s1_hold_addr", MEM_ADDR2, 32'h104);
        MEM_ACK = 1'b1;
        tick();
        MEM_ACK = 1'b0;
        chk("s1_done", done, 1);
        chk("s1_done_tag", done_tag, 1);
        chk("s1_done_err", done_err, 0);
        chk("s1_write_off", MEM_WRITE, 0);
        chk("s1_addr_zero", MEM_ADDR2, 0);
        tick();
        chk("s1_done_pulse", done, 0);
        chk("s1_count_end", count, 0);

        // Scenario 2: store data arrives on the CDB
        issue(4'd2, 32'h200, 32'h0, 32'h0, 1'b0, 4'd5, 3'b010);
        nw = 0;
        for (int i = 0; i < 3; i++) begin
            if (MEM_WRITE) nw++;
            tick();
        end
        chk("s2_no_early_write", nw, 0);
        cdb_valid = 1'b1;
        cdb_tag   = 4'd5;
        cdb_data  = 32'h55;
        tick();
        cdb_valid = 1'b0;
        chk("s2_capture_no_write", MEM_WRITE, 0);
        tick();
        chk("s2_write", MEM_WRITE, 1);
        chk("s2_data", MEM_WRITE_DATA, 32'h55);
        chk("s2_addr", MEM_ADDR2, 32'h200);
        MEM_ACK = 1'b1;
        tick();
        MEM_ACK = 1'b0;
        chk("s2_done_tag", done_tag, 2);
        tick();

        // Scenario 3: fill the queue, then drain in order
        issue(4'd3, 32'h300, 32'h0, 32'h33, 1'b1, 4'd0, 3'b010);
        issue(4'd4, 32'h304, 32'h0, 32'h44, 1'b1, 4'd0, 3'b010);
        issue(4'd6, 32'h308, 32'h0, 32'h66, 1'b1, 4'd0, 3'b010);
        issue(4'd7, 32'h30C, 32'h0, 32'h77, 1'b1, 4'd0, 3'b010);
        chk("s3_full_count", count, DEPTH);
        chk("s3_full_ready", issue_ready, 0);
        MEM_ACK = 1'b1;
        nd = 0;
        for (int i = 0; i < 30; i++) begin
            if (done) begin
                if (nd < 8) got_tags[nd] = done_tag;
                nd++;
            end
            tick();
        end
        MEM_ACK = 1'b0;
        chk("s3_ndone", nd, 4);
        chk("s3_order0", got_tags[0], 3);
        chk("s3_order1", got_tags[1], 4);
        chk("s3_order2", got_tags[2], 6);
        chk("s3_order3", got_tags[3], 7);
        chk("s3_count_end", count, 0);
        chk("s3_ready_end", issue_ready, 1);

        // Scenario 4: misaligned sh at 0x101
        issue(4'd8, 32'h100, 32'h1, 32'h1234, 1'b1, 4'd0, 3'b001);
        seen = 1'b0;
        nw = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            if (MEM_WRITE) nw++;
            if (done) begin
                seen = 1'b1;
                chk("s4_done_err", done_err, 1);
                chk("s4_done_tag", done_tag, 8);
            end else begin
                tick();
            end
        end
        chk("s4_done_seen", seen, 1);
        chk("s4_never_write", nw, 0);
        tick();
        chk("s4_count_end", count, 0);

        // Scenario 5: flush with head in WRITE
        issue(4'd9,  32'h500, 32'h0, 32'h99, 1'b1, 4'd0, 3'b010);
        issue(4'd10, 32'h504, 32'h0, 32'hAA, 1'b1, 4'd0, 3'b010);
        issue(4'd11, 32'h508, 32'h0, 32'hBB, 1'b1, 4'd0, 3'b010);
        chk("s5_count3", count, 3);
        chk("s5_head_write", MEM_WRITE, 1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("s5_count_flush", count, 1);
        chk("s5_write_kept", MEM_WRITE, 1);
        chk("s5_addr_kept", MEM_ADDR2, 32'h500);
        MEM_ACK = 1'b1;
        tick();
        MEM_ACK = 1'b0;
        chk("s5_done", done, 1);
        chk("s5_done_tag", done_tag, 9);
        tick();
        nd = 0;
        nw = 0;
        for (int i = 0; i < 8; i++) begin
            if (done) nd++;
            if (MEM_WRITE) nw++;
            tick();
        end
        chk("s5_no_more_done", nd, 0);
        chk("s5_no_more_write", nw, 0);
        chk("s5_count_end", count, 0);

        // Scenario 6: reset during WRITE
        issue(4'd12, 32'h600, 32'h0, 32'hCC, 1'b1, 4'd0, 3'b010);
        tick();
        chk("s6_write", MEM_WRITE, 1);
        #2;
        RST_N = 1'b0;
        #1;
        chk("s6_write_cleared", MEM_WRITE, 0);
        chk("s6_count_cleared", count, 0);
        chk("s6_ready", issue_ready, 1);
        tick();
        RST_N = 1'b1;
        nd = 0;
        for (int i = 0; i < 5; i++) begin
            if (done) nd++;
            tick();
        end
        chk("s6_no_done", nd, 0);

        // Issue in the same cycle as flush is dropped
        flush = 1'b1;
        issue(4'd13, 32'h700, 32'h0, 32'hDD, 1'b1, 4'd0, 3'b010);
        flush = 1'b0;
        chk("s7_count", count, 0);
        nw = 0;
        for (int i = 0; i < 3; i++) begin
            if (MEM_WRITE) nw++;
            tick();
        end
        chk("s7_no_write", nw, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/store_queue.md
STORE_QUEUE -- requirements
Module: store_queue

Interface
REQ-001 Parameter DEPTH, 4, number of queue entries; power of two, 2..16.
REQ-002 Parameter XLEN, 32, address and data width.
REQ-003 Parameter TAG_W, 4, reservation-station tag width; equals $bits(RS_tag_type).
REQ-004 Clock and reset SHALL be one clock and an asynchronous active-low reset:
- CLK  in  1  rising-edge clock.
- RST_N  in  1  asynchronous active-low reset.
REQ-005 Issue ports:
- issue_valid  in  1  store offered.
- issue_ready  out  1  queue can accept.
- issue_tag  in  TAG_W  store's own tag.
- issue_v1/v2/v3  in  XLEN  base/offset/store-data values.
- issue_v1_ok/v2_ok/v3_ok  in  1  corresponding value is valid.
- issue_q1/q2/q3  in  TAG_W  producer tag when not valid.
- issue_mem_type  in  3  {sign, size[1:0]}.
REQ-006 Common data bus snoop ports:
- cdb_valid  in  1  broadcast present.
- cdb_tag  in  TAG_W  producer tag.
- cdb_data  in  XLEN  broadcast value.
REQ-007 Memory ports:
- MEM_ADDR2  out  XLEN  store address.
- MEM_WRITE  out  1  write request.
- MEM_WRITE_DATA  out  XLEN  store data.
- MEM_SIGN  out  1  mem_type[2].
- MEM_SIZE  out  2  mem_type[1:0].
- MEM_ACK  in  1  write accepted.
REQ-008 Completion and control ports:
- done  out  1  one-cycle completion pulse.
- done_tag  out  TAG_W  tag of the completed store.
- done_err  out  1  misaligned store, no write performed.
- flush  in  1  squash speculative stores.
- count  out  $clog2(DEPTH)+1  occupied entries.

Function
REQ-009 The queue SHALL be a circular FIFO with head/tail pointers wrapping modulo DEPTH; issue_ready = (count < DEPTH), with no same-cycle pop bypass.
REQ-010 When issue_valid && issue_ready, the queue SHALL write the entry at tail next edge; an operand whose ok=0 but whose q matches cdb_tag while cdb_valid SHALL be captured from cdb_data in that same write.
REQ-011 Every cycle, each occupied entry with an invalid operand whose q equals cdb_tag while cdb_valid SHALL capture cdb_data and set the operand valid; multiple entries may capture the same broadcast.
REQ-012 Address SHALL be v1+v2 truncated to XLEN bits (wrap-around, no overflow flag).
REQ-013 Only the head entry SHALL issue to memory; stores commit strictly in program order.
REQ-014 The head FSM SHALL have states IDLE, WRITE, RESP.
REQ-015 IDLE -> WRITE on the edge after the head entry has all three operands valid and is aligned.
REQ-016 IDLE -> RESP directly when the head entry is fully valid but misaligned (size 01 with addr[0]=1, or size 10 with addr[1:0]!=0); MEM_WRITE SHALL never assert for it.
REQ-017 In WRITE, MEM_WRITE=1 and MEM_ADDR2/MEM_WRITE_DATA/MEM_SIGN/MEM_SIZE SHALL hold stable until the MEM_ACK cycle; on MEM_ACK go to RESP.
REQ-018 In RESP, done=1 for exactly one cycle with done_tag=head tag and done_err set if misaligned; head pops; go to IDLE.
REQ-019 Minimum latency: head ready in cycle N -> MEM_WRITE in N+1; MEM_ACK in cycle M -> done in M+1.
REQ-020 A simultaneous push and pop SHALL leave count unchanged.
REQ-021 Flush SHALL discard every entry except a head in WRITE or RESP, which completes normally; tail SHALL be set to head+1 in that case, else to head.
REQ-022 Flush in the same cycle as issue_valid SHALL drop the issued store.
REQ-023 Memory outputs SHALL be 0 outside WRITE.

Reset
REQ-024 RST_N low SHALL asynchronously clear pointers, count, entry-valid bits, and the FSM (to IDLE); all outputs read 0 except issue_ready=1.
REQ-025 Reset during WRITE SHALL drop the request without generating done.

Structure
REQ-026 RS_tag_type, TAG_W, and the mem_type size encodings (00 byte, 01 half, 10 word) SHALL live in the shared otter_pkg.
REQ-027 Per-entry operand storage and CDB capture SHALL be one sub-module, sq_entry, instantiated DEPTH times.

Verification
REQ-028 Scenario 1: issue sw with v1=0x100, v2=0x4, v3=0xDEADBEEF, all ok -> MEM_WRITE next cycle, MEM_ADDR2=0x104, MEM_SIZE=10; ack -> done with the tag one cycle later.
REQ-029 Scenario 2: issue with v3_ok=0, q3=5, then cdb tag 5 data 0x55 -> MEM_WRITE_DATA=0x55; no write before capture.
REQ-030 Scenario 3: fill DEPTH stores with MEM_ACK held low -> issue_ready=0 and count=DEPTH; then ack -> done pulses appear in issue order.
REQ-031 Scenario 4: sh at address 0x101 -> done_err=1 and MEM_WRITE never asserts.
REQ-032 Scenario 5: three stores queued, head in WRITE, flush -> head completes, count becomes 0 after its done, other tags never reported.
REQ-033 Scenario 6: RST_N low mid-WRITE -> MEM_WRITE=0 immediately and count=0.
